stream_pkt_fifo: RTL and testbench

- Parametrised AXI-Stream FIFO; next generation of the single-channel stream buffer.
- Adds configurable field widths and depth, an occupancy level, and a completed-packet count.
- Optional store-and-forward packet mode: output is held back until a whole packet (t_last) is buffered. A cut-through escape prevents deadlock on packets longer than DEPTH.
- Sits between stream producers and consumers that need burst-atomic delivery, e.g. DMA or packet egress.

---
 rtl/stream_pkt_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_stream_pkt_fifo.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pkt_fifo.sv
// ============================================================================
// stream_pkt_fifo
// ----------------------------------------------------------------------------
// Parametrised AXI-Stream FIFO with optional store-and-forward packet mode.
//
// Every accepted beat carries seven fields together (data, strb, keep, id,
// dest, user, last) and leaves in the same order, unchanged. Two counters
// are kept:
//   level      number of beats currently stored
//   pkt_count  number of stored beats with t_last set (whole packets held)
//
// With PACKET_MODE=1 the output only presents data once at least one whole
// packet is buffered. A packet longer than DEPTH can never be complete inside
// the buffer, so once the FIFO fills with no t_last stored, a cut-through
// flag opens the output and that packet streams through as a plain FIFO.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   s_t_valid/s_t_ready  upstream handshake
//   s_t_data/strb/keep   upstream payload and byte qualifiers
//   s_t_id/dest/user     upstream sideband
//   s_t_last             upstream end of packet
//   m_t_*                downstream beat at the read pointer, same fields
//   level                stored beat count
//   pkt_count            stored complete-packet count
// ============================================================================
module stream_pkt_fifo #(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 1,
    parameter int DEST_WIDTH  = 1,
    parameter int USER_WIDTH  = 1,
    parameter int PACKET_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         s_t_valid,
    output logic                         s_t_ready,
    input  logic [ID_WIDTH-1:0]          s_t_id,
    input  logic [DEST_WIDTH-1:0]        s_t_dest,
    input  logic [USER_WIDTH-1:0]        s_t_user,
    input  logic [DATA_WIDTH-1:0]        s_t_data,
    input  logic [DATA_WIDTH/8-1:0]      s_t_strb,
    input  logic [DATA_WIDTH/8-1:0]      s_t_keep,
    input  logic                         s_t_last,

    output logic                         m_t_valid,
    input  logic                         m_t_ready,
    output logic [ID_WIDTH-1:0]          m_t_id,
    output logic [DEST_WIDTH-1:0]        m_t_dest,
    output logic [USER_WIDTH-1:0]        m_t_user,
    output logic [DATA_WIDTH-1:0]        m_t_data,
    output logic [DATA_WIDTH/8-1:0]      m_t_strb,
    output logic [DATA_WIDTH/8-1:0]      m_t_keep,
    output logic                         m_t_last,

    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count
);

    // ------------------------------------------------------------------------
    // Derived sizes. The pointer is at least one bit wide so DEPTH=1 still
    // has a legal (always zero) pointer register.
    // ------------------------------------------------------------------------
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic             GATE_PKT = (PACKET_MODE != 0);

    // ------------------------------------------------------------------------
    // Parameter sanity: an empty FIFO or a payload that does not split into
    // whole bytes cannot be built, so stop elaboration outright.
    // ------------------------------------------------------------------------
    if (DEPTH < 1) begin : g_badDepth
        $fatal(1, "stream_pkt_fifo: DEPTH must be at least 1 (got %0d)", DEPTH);
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_badWidth
        $fatal(1, "stream_pkt_fifo: DATA_WIDTH must be a multiple of 8 (got %0d)", DATA_WIDTH);
    end

    // ------------------------------------------------------------------------
    // One storage entry holds a whole beat so the fields cannot drift apart.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [DEST_WIDTH-1:0] dest;
        logic [ID_WIDTH-1:0]   id;
        logic [STRB_W-1:0]     keep;
        logic [STRB_W-1:0]     strb;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t             mem_q [DEPTH];

    logic [PTR_W-1:0]  wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q,    rdPtr_d;
    logic [LVL_W-1:0]  levelCnt_q, levelCnt_d;
    logic [LVL_W-1:0]  pktCnt_q,   pktCnt_d;
    logic              ct_q,       ct_d;

    beat_t             wrBeat;
    beat_t             rdBeat;
    logic              wrEn;
    logic              rdEn;
    logic              wrLast;
    logic              rdLast;
    logic              outOpen;

    // ------------------------------------------------------------------------
    // Handshake and output presentation. Ready depends only on registered
    // occupancy, so there is no combinational path from m_t_ready back to
    // s_t_ready. In packet mode the output opens once a whole packet is held
    // or the cut-through flag is set; both only rise while beats are waiting,
    // and ct only falls on a transfer, so a presented beat is never withdrawn.
    // Everything visible is forced idle while reset is held.
    // ------------------------------------------------------------------------
    always_comb begin
        wrBeat.last = s_t_last;
        wrBeat.user = s_t_user;
        wrBeat.dest = s_t_dest;
        wrBeat.id   = s_t_id;
        wrBeat.keep = s_t_keep;
        wrBeat.strb = s_t_strb;
        wrBeat.data = s_t_data;

        rdBeat      = mem_q[rdPtr_q];

        outOpen     = !GATE_PKT || (pktCnt_q != '0) || ct_q;

        s_t_ready   = !rst && (levelCnt_q < DEPTH_L);
        m_t_valid   = !rst && (levelCnt_q != '0) && outOpen;

        wrEn        = s_t_valid && s_t_ready;
        rdEn        = m_t_valid && m_t_ready;
        wrLast      = wrEn && s_t_last;
        rdLast      = rdEn && rdBeat.last;

        m_t_last    = rdBeat.last;
        m_t_user    = rdBeat.user;
        m_t_dest    = rdBeat.dest;
        m_t_id      = rdBeat.id;
        m_t_keep    = rdBeat.keep;
        m_t_strb    = rdBeat.strb;
        m_t_data    = rdBeat.data;

        level       = rst ? '0 : levelCnt_q;
        pkt_count   = rst ? '0 : pktCnt_q;
    end

    // ------------------------------------------------------------------------
    // Next-state for pointers and counters. Pointers wrap explicitly at
    // DEPTH-1 so non-power-of-two depths work. A simultaneous write and read
    // leaves the counters where they are.
    // ------------------------------------------------------------------------
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        levelCnt_d = levelCnt_q;
        pktCnt_d   = pktCnt_q;

        if (wrEn) begin
            wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
        end
        if (rdEn) begin
            rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
        end

        case ({wrEn, rdEn})
            2'b10:   levelCnt_d = levelCnt_q + LVL_W'(1);
            2'b01:   levelCnt_d = levelCnt_q - LVL_W'(1);
            default: levelCnt_d = levelCnt_q;
        endcase

        case ({wrLast, rdLast})
            2'b10:   pktCnt_d = pktCnt_q + LVL_W'(1);
            2'b01:   pktCnt_d = pktCnt_q - LVL_W'(1);
            default: pktCnt_d = pktCnt_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Cut-through flag. A full buffer with no t_last inside can only be an
    // oversized packet, so open the output; close it again when that packet's
    // last beat leaves. While ct is set the head packet has no stored t_last,
    // so the set and clear conditions never coincide.
    // ------------------------------------------------------------------------
    always_comb begin
        ct_d = ct_q;
        if ((levelCnt_q == DEPTH_L) && (pktCnt_q == '0)) begin
            ct_d = 1'b1;
        end else if (ct_q && rdLast) begin
            ct_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Control state register. Reset empties the FIFO logically, throwing away
    // any partial packet; storage itself is left alone.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            levelCnt_q <= '0;
            pktCnt_q   <= '0;
            ct_q       <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            levelCnt_q <= levelCnt_d;
            pktCnt_q   <= pktCnt_d;
            ct_q       <= ct_d;
        end
    end

    // ------------------------------------------------------------------------
    // Beat storage. Written only on an accepted beat; never reset. A full
    // FIFO refuses writes, so the entry under the read pointer cannot be
    // overwritten while it is being presented.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wrBeat;
        end
    end

endmodule

// File: tb/tb_stream_pkt_fifo.sv
// ============================================================================
// tb_stream_pkt_fifo
// ----------------------------------------------------------------------------
// Four instances of stream_pkt_fifo share clock, reset and upstream payload;
// each has its own valid/ready so one instance is exercised at a time:
//   0: DEPTH=4 plain   1: DEPTH=3 plain   2: DEPTH=8 packet   3: DEPTH=4 packet
// A scoreboard queue of expected beats is filled on each accepted write and
// drained on each output transfer. Occupancy, packet count, valid, ready and
// output hold under backpressure are compared against a small model every
// cycle.
// ============================================================================
module tb_stream_pkt_fifo;

    localparam int NDUT       = 4;
    localparam int DEPTHS [4] = '{4, 3, 8, 4};
    localparam int PMODES [4] = '{0, 0, 1, 1};
    localparam int BW         = 48;

    logic          clk;
    logic          rst;

    logic          sValid [NDUT];
    logic          mReady [NDUT];
    logic [31:0]   sData;
    logic [3:0]    sStrb;
    logic [3:0]    sKeep;
    logic [1:0]    sId;
    logic [1:0]    sDest;
    logic [2:0]    sUser;
    logic          sLast;

    logic          sReadyO [NDUT];
    logic          mValidO [NDUT];
    logic [BW-1:0] mBeatO  [NDUT];
    logic [3:0]    levelO  [NDUT];
    logic [3:0]    pktO    [NDUT];

    logic [BW-1:0] beatQ [$];
    logic          ctModel;
    logic          holdPending;
    logic [BW-1:0] heldBeat;
    logic          lastWrFire;
    int            vectors;
    int            miscompares;
    int            emitCnt;

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Device instances, one per configuration, outputs packed into a beat.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D  = DEPTHS[g];
        localparam int LW = $clog2(D + 1);
        logic [LW-1:0] lvl;
        logic [LW-1:0] pc;
        logic [31:0]   d;
        logic [3:0]    st;
        logic [3:0]    kp;
        logic [1:0]    id;
        logic [1:0]    ds;
        logic [2:0]    us;
        logic          ls;

        stream_pkt_fifo #(
            .DEPTH       (D),
            .DATA_WIDTH  (32),
            .ID_WIDTH    (2),
            .DEST_WIDTH  (2),
            .USER_WIDTH  (3),
            .PACKET_MODE (PMODES[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .s_t_valid (sValid[g]),
            .s_t_ready (sReadyO[g]),
            .s_t_id    (sId),
            .s_t_dest  (sDest),
            .s_t_user  (sUser),
            .s_t_data  (sData),
            .s_t_strb  (sStrb),
            .s_t_keep  (sKeep),
            .s_t_last  (sLast),
            .m_t_valid (mValidO[g]),
            .m_t_ready (mReady[g]),
            .m_t_id    (id),
            .m_t_dest  (ds),
            .m_t_user  (us),
            .m_t_data  (d),
            .m_t_strb  (st),
            .m_t_keep  (kp),
            .m_t_last  (ls),
            .level     (lvl),
            .pkt_count (pc)
        );

        assign mBeatO[g] = {ls, us, ds, id, kp, st, d};
        assign levelO[g] = 4'(lvl);
        assign pktO[g]   = 4'(pc);
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Random sideband around a chosen payload and last flag.
    function automatic logic [BW-1:0] makeBeat(input logic [31:0] data, input logic last);
        return {last, 3'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), data};
    endfunction

    // Drive one cycle's inputs for the selected instance.
    task automatic applyStimulus(input int sel, input logic v, input logic [BW-1:0] beat,
                                 input logic r);
        sValid[sel] = v;
        mReady[sel] = r;
        {sLast, sUser, sDest, sId, sKeep, sStrb, sData} = beat;
    endtask

    // Compare the selected instance against the model, then account for
    // whatever transfers the coming clock edge will perform.
    task automatic sampleCycle(input int sel);
        int   size;
        int   pkts;
        logic expValid;
        logic rdFire;
        logic wrFire;
        logic lastOut;
        logic [BW-1:0] exp;

        size    = beatQ.size();
        pkts    = 0;
        lastOut = 1'b0;
        foreach (beatQ[i]) if (beatQ[i][BW-1]) pkts++;

        if (rst) begin
            checkOutput("rstLevel",  levelO[sel],  0);
            checkOutput("rstPkt",    pktO[sel],    0);
            checkOutput("rstMValid", mValidO[sel], 0);
            checkOutput("rstSReady", sReadyO[sel], 0);
            beatQ.delete();
            ctModel     = 1'b0;
            holdPending = 1'b0;
            lastWrFire  = 1'b0;
            return;
        end

        expValid = (size > 0) && ((PMODES[sel] == 0) || (pkts > 0) || ctModel);
        checkOutput("level",    levelO[sel],  size);
        checkOutput("pktCount", pktO[sel],    pkts);
        checkOutput("mValid",   mValidO[sel], expValid);
        checkOutput("sReady",   sReadyO[sel], size < DEPTHS[sel]);

        if (holdPending) begin
            checkOutput("validDrop", mValidO[sel], 1);
            if (mValidO[sel]) checkOutput("holdBeat", mBeatO[sel], heldBeat);
        end

        rdFire = mValidO[sel] && mReady[sel];
        wrFire = sValid[sel] && sReadyO[sel];

        if (rdFire) begin
            if (size == 0) begin
                checkOutput("underflow", mValidO[sel], 0);
            end else begin
                exp     = beatQ.pop_front();
                lastOut = exp[BW-1];
                checkOutput("beat", mBeatO[sel], exp);
                emitCnt++;
            end
        end
        if (wrFire) begin
            beatQ.push_back({sLast, sUser, sDest, sId, sKeep, sStrb, sData});
        end
        lastWrFire  = wrFire;
        ctModel     = (ctModel && !(rdFire && lastOut)) ||
                      ((size == DEPTHS[sel]) && (pkts == 0));
        holdPending = mValidO[sel] && !mReady[sel];
        heldBeat    = mBeatO[sel];
    endtask

    task automatic runCycle(input int sel);
        #1;
        sampleCycle(sel);
        @(negedge clk);
    endtask

    task automatic startTest(input int sel);
        holdPending = 1'b0;
        ctModel     = 1'b0;
        beatQ.delete();
        applyStimulus(sel, 1'b0, '0, 1'b0);
    endtask

    // Empty the selected instance with a cycle budget.
    task automatic drain(input int sel, input int budget);
        for (int i = 0; i < budget && beatQ.size() > 0; i++) begin
            applyStimulus(sel, 1'b0, '0, 1'b1);
            runCycle(sel);
        end
        #1;
        checkOutput("drainLevel", levelO[sel], 0);
        checkOutput("drainQueue", beatQ.size(), 0);
        @(negedge clk);
    endtask

    // Random valid/ready with random-length packets, then close the packet.
    task automatic randomTraffic(input int sel, input int cycles);
        int            pos;
        int            len;
        logic [BW-1:0] beat;
        pos  = 0;
        len  = int'($urandom_range(1, 6));
        beat = makeBeat($urandom, len == 1);
        startTest(sel);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(sel, ($urandom % 4) != 0, beat, ($urandom % 3) != 0);
            runCycle(sel);
            if (lastWrFire) begin
                pos++;
                if (pos == len) begin
                    pos = 0;
                    len = int'($urandom_range(1, 6));
                end
                beat = makeBeat($urandom, pos == len - 1);
            end
        end
        for (int c = 0; c < 40 && pos != 0; c++) begin
            applyStimulus(sel, 1'b1, beat, 1'b1);
            runCycle(sel);
            if (lastWrFire) begin
                pos++;
                if (pos == len) pos = 0;
                beat = makeBeat($urandom, pos == len - 1);
            end
        end
        checkOutput("pktClosed", pos, 0);
        drain(sel, 40);
    endtask

    // Hard stop should anything wedge outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            e0;
        int            acc;
        logic [BW-1:0] beat;

        vectors     = 0;
        miscompares = 0;
        emitCnt     = 0;
        ctModel     = 1'b0;
        holdPending = 1'b0;
        heldBeat    = '0;
        lastWrFire  = 1'b0;
        rst         = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            sValid[i] = 1'b0;
            mReady[i] = 1'b0;
        end
        {sLast, sUser, sDest, sId, sKeep, sStrb, sData} = '0;

        $display("[TB] reset");
        @(negedge clk);
        runCycle(0);
        runCycle(0);
        rst = 1'b0;
        runCycle(0);

        $display("[TB] plain DEPTH=4 fill then drain");
        startTest(0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1'b1, makeBeat(32'h11 * i, i == 4), 1'b0);
            runCycle(0);
        end
        #1;
        checkOutput("fullLevel", levelO[0], 4);
        checkOutput("fullReady", sReadyO[0], 0);
        @(negedge clk);
        e0 = emitCnt;
        drain(0, 10);
        checkOutput("fillDrainCount", emitCnt - e0, 4);

        $display("[TB] plain DEPTH=3 streaming");
        startTest(1);
        e0 = emitCnt;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 1'b1, makeBeat(32'(i), (i % 5) == 4), 1'b1);
            runCycle(1);
        end
        applyStimulus(1, 1'b0, '0, 1'b1);
        runCycle(1);
        checkOutput("streamCount", emitCnt - e0, 100);
        drain(1, 5);

        $display("[TB] packet DEPTH=8 three-beat packet");
        startTest(2);
        e0 = emitCnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 1'b1, makeBeat(32'hA0 + 32'(i), i == 2), 1'b1);
            runCycle(2);
        end
        drain(2, 10);
        checkOutput("pktCount3", emitCnt - e0, 3);

        $display("[TB] packet DEPTH=4 oversized packet cut-through");
        startTest(3);
        e0   = emitCnt;
        acc  = 0;
        beat = makeBeat(32'hB0, 1'b0);
        for (int c = 0; c < 40 && acc < 6; c++) begin
            applyStimulus(3, 1'b1, beat, 1'b1);
            runCycle(3);
            if (lastWrFire) begin
                acc++;
                beat = makeBeat(32'hB0 + 32'(acc), acc == 5);
            end
        end
        checkOutput("ctAccepted", acc, 6);
        drain(3, 20);
        checkOutput("ctDrained", emitCnt - e0, 6);

        $display("[TB] random backpressure");
        randomTraffic(3, 300);
        randomTraffic(0, 300);
        randomTraffic(2, 300);

        $display("[TB] reset mid-packet");
        startTest(3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3, 1'b1, makeBeat(32'hC0 + 32'(i), 1'b0), 1'b0);
            runCycle(3);
        end
        #1;
        checkOutput("preRstLevel", levelO[3], 3);
        @(negedge clk);
        applyStimulus(3, 1'b0, '0, 1'b0);
        rst = 1'b1;
        runCycle(3);
        rst = 1'b0;
        runCycle(3);
        e0 = emitCnt;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(3, 1'b1, makeBeat(32'hD0 + 32'(i), i == 1), 1'b1);
            runCycle(3);
        end
        drain(3, 10);
        checkOutput("postRstPkt", emitCnt - e0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
